pipe_sub_32: RTL and testbench

//  Pipelined 32-bit subtractor (A - B - BIN) with valid/ready handshake; inverse-direction

---
 rtl/pipe_sub_32.sv | 118 +++++++++++
 tb/tb_pipe_sub_32.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pipe_sub_32.sv
// Pipelined WIDTH-bit subtractor (a - b - bin): borrow ripples CHUNK bits per stage,
// with a valid/ready handshake and zero/neg/ovf flags registered with the last stage.
module pipe_sub_32 #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int STAGES = WIDTH / CHUNK;

  if (WIDTH % CHUNK != 0) begin : g_width_chk
    $error("pipe_sub_32: WIDTH must be a multiple of CHUNK");
  end

  // Chunk subtract: MSB of the result is the borrow-out of this chunk.
  function automatic logic [CHUNK:0] sub_chunk(input logic [CHUNK-1:0] x,
                                               input logic [CHUNK-1:0] y,
                                               input logic             bi);
    return {1'b0, x} - {1'b0, y} - {{CHUNK{1'b0}}, bi};
  endfunction

  logic             adv;
  logic             vld_i [STAGES];
  logic             brw_i [STAGES];
  logic [WIDTH-1:0] a_i   [STAGES];
  logic [WIDTH-1:0] b_i   [STAGES];
  logic [WIDTH-1:0] res_i [STAGES];
  logic [WIDTH-1:0] res_nx[STAGES];
  logic             brw_nx[STAGES];
  logic             vld_p [STAGES];
  logic             brw_p [STAGES];
  logic [WIDTH-1:0] a_p   [STAGES];
  logic [WIDTH-1:0] b_p   [STAGES];
  logic [WIDTH-1:0] res_p [STAGES];
  logic             zero_q, neg_q, ovf_q;

  assign adv      = ~vld_p[STAGES-1] | out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic [CHUNK:0] part;

    if (k == 0) begin : g_head
      assign vld_i[k] = in_valid;
      assign brw_i[k] = bin;
      assign a_i[k]   = a;
      assign b_i[k]   = b;
      assign res_i[k] = '0;
    end else begin : g_body
      assign vld_i[k] = vld_p[k-1];
      assign brw_i[k] = brw_p[k-1];
      assign a_i[k]   = a_p[k-1];
      assign b_i[k]   = b_p[k-1];
      assign res_i[k] = res_p[k-1];
    end

    assign part = sub_chunk(a_i[k][k*CHUNK +: CHUNK], b_i[k][k*CHUNK +: CHUNK], brw_i[k]);

    always_comb begin
      res_nx[k]                   = res_i[k];
      res_nx[k][k*CHUNK +: CHUNK] = part[CHUNK-1:0];
      brw_nx[k]                   = part[CHUNK];
    end

    // Stage k boundary: lower result bits travel along with the remaining operands.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_p[k] <= 1'b0;
        brw_p[k] <= 1'b0;
        a_p[k]   <= '0;
        b_p[k]   <= '0;
        res_p[k] <= '0;
      end else if (adv) begin
        vld_p[k] <= vld_i[k];
        brw_p[k] <= brw_nx[k];
        a_p[k]   <= a_i[k];
        b_p[k]   <= b_i[k];
        res_p[k] <= res_nx[k];
      end
    end
  end

  // Final stage boundary: flags registered alongside the completed difference.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (adv) begin
      zero_q <= (res_nx[STAGES-1] == '0);
      neg_q  <= res_nx[STAGES-1][WIDTH-1];
      ovf_q  <= (a_i[STAGES-1][WIDTH-1] != b_i[STAGES-1][WIDTH-1]) &&
                (res_nx[STAGES-1][WIDTH-1] != a_i[STAGES-1][WIDTH-1]);
    end
  end

  assign out_valid = vld_p[STAGES-1];
  assign diff      = res_p[STAGES-1];
  assign bout      = brw_p[STAGES-1];
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_sub_32.sv
// Directed and streaming bench for pipe_sub_32: latency, flags, handshake hold,
// async reset flush and a long random run against a 33-bit reference subtract.
module tb_pipe_sub_32;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] a, b;
  logic             bin;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout, zero, neg, ovf;

  int checks = 0;
  int errors = 0;

  pipe_sub_32 #(.WIDTH(WIDTH), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin),
    .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .zero(zero), .neg(neg), .ovf(ovf)
  );

  always #5 clk = ~clk;

  logic [35:0] obs;
  assign obs = {diff, bout, zero, neg, ovf};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y, input logic bi);
    logic [32:0] r;
    logic [31:0] d;
    r = {1'b0, x} - {1'b0, y} - {32'd0, bi};
    d = r[31:0];
    return {d, r[32], (d == 32'd0), d[31], (x[31] != y[31]) && (d[31] != x[31])};
  endfunction

  // Single op with an idle pipe and out_ready=1; entered and left on a negedge.
  task automatic run_one(input string tag, input logic [31:0] x, input logic [31:0] y,
                         input logic bi, input logic [35:0] exp);
    int lat;
    out_ready = 1'b1;
    a = x; b = y; bin = bi; in_valid = 1'b1;
    #1;
    check({tag, "_rdy"}, in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, "_lat"}, lat, STAGES - 1);
    check(tag, obs, exp);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_drain"}, out_valid, 1'b0);
  endtask

  // Streaming run with random stalls; scoreboard enforces order, no drops/dups, hold.
  task automatic stream(input string tag, input int n, input int rdy_pct);
    logic [35:0] q[$];
    logic [35:0] snap;
    bit          held;
    int          sent, recv, cyc, r;
    q.delete();
    sent = 0; recv = 0; cyc = 0; held = 0; snap = '0;
    while (recv < n && cyc < n * 8 + 100) begin
      if (held) check({tag, "_hold"}, obs, snap);
      out_ready = ($urandom_range(99) < rdy_pct);
      if (sent < n) begin
        in_valid = ($urandom_range(9) != 0);
        a = $urandom;
        r = $urandom_range(7);
        b = (r == 0) ? a : (r == 1) ? a + 32'd1 : $urandom;
        bin = $urandom_range(1);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      check({tag, "_inrdy"}, in_ready, !(out_valid && !out_ready));
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, bin));
        sent++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) check({tag, "_dup"}, obs, '1);
        else check(tag, obs, q.pop_front());
        recv++;
      end
      held = out_valid && !out_ready;
      snap = obs;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    check({tag, "_count"}, recv, n);
    check({tag, "_empty"}, q.size(), 0);
  endtask

  initial begin
    int stale;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", out_valid, 1'b0);
    check("rst_out", obs, 36'd0);
    rst_n = 1'b1;
    #1;
    check("rst_inrdy", in_ready, 1'b1);
    @(negedge clk);

    run_one("sub_5_3",    32'd5,          32'd3,          1'b0, {32'h00000002, 4'b0000});
    run_one("sub_0_1",    32'd0,          32'd1,          1'b0, {32'hFFFFFFFF, 4'b1010});
    run_one("sub_7_7",    32'd7,          32'd7,          1'b0, {32'h00000000, 4'b0100});
    run_one("ovf_min",    32'h80000000,   32'd1,          1'b0, {32'h7FFFFFFF, 4'b0001});
    run_one("xchunk",     32'h00000100,   32'd0,          1'b1, {32'h000000FF, 4'b0000});
    run_one("ovf_max",    32'h7FFFFFFF,   32'hFFFFFFFF,   1'b0, {32'h80000000, 4'b1011});
    run_one("bin_wrap",   32'd0,          32'd0,          1'b1, {32'hFFFFFFFF, 4'b1010});
    run_one("bin_top",    32'hFFFFFFFF,   32'd0,          1'b1, {32'hFFFFFFFE, 4'b0010});

    stream("strm16", 16, 50);

    // Fill the pipe while the consumer stalls, then reset asynchronously.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; a = 32'd100 + i; b = 32'd1; bin = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("full_valid", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_out", obs, 36'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("no_stale", stale, 0);
    run_one("post_rst", 32'd9, 32'd4, 1'b0, {32'h00000005, 4'b0000});

    stream("rand10k", 10000, 75);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
